// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit fan speed from a PWM waveform by counting high samples
// over back-to-back windows of 2**WIDTH clocks and publishing count-1.
module pwm_duty_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] duty,
    output logic             duty_valid,
    output logic             duty_changed,
    output logic             signal_lost,
    output logic             busy_sync
);

    localparam int PERIOD = 2 ** WIDTH;
    localparam logic [WIDTH:0] ONE       = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] PERIOD_M1 = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic {
        WAIT_EDGE,
        MEASURE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   s;
    logic                   s_prev;
    logic                   rise;
    logic [WIDTH:0]         win_cnt;
    logic [WIDTH:0]         high_cnt;
    logic [WIDTH:0]         timeout;
    logic [WIDTH:0]         hc_final;
    logic [WIDTH-1:0]       new_duty;

    assign s         = sync_ff[SYNC_STAGES-1];
    assign rise      = s & ~s_prev;
    assign busy_sync = (state == WAIT_EDGE);

    always_comb begin
        hc_final = high_cnt + {{WIDTH{1'b0}}, s};
        new_duty = '0;
        if (hc_final != '0) begin
            new_duty = WIDTH'(hc_final - ONE);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_ff <= '0;
            s_prev  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pwm_in};
            s_prev  <= s;
        end
    end

    // Window sample 1 is captured on the entry clock; the clock capturing
    // sample PERIOD publishes and clears so the next window follows with no gap.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= WAIT_EDGE;
            win_cnt      <= '0;
            high_cnt     <= '0;
            timeout      <= '0;
            duty         <= '0;
            duty_valid   <= 1'b0;
            duty_changed <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            duty_valid   <= 1'b0;
            duty_changed <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state    <= MEASURE;
                        high_cnt <= ONE;
                        win_cnt  <= ONE;
                    end else if (timeout == PERIOD_M1) begin
                        state    <= MEASURE;
                        high_cnt <= {{WIDTH{1'b0}}, s};
                        win_cnt  <= ONE;
                    end else begin
                        timeout <= timeout + ONE;
                    end
                end
                MEASURE: begin
                    if (win_cnt == PERIOD_M1) begin
                        duty         <= new_duty;
                        duty_valid   <= 1'b1;
                        duty_changed <= (new_duty != duty);
                        signal_lost  <= (hc_final == '0);
                        high_cnt     <= '0;
                        win_cnt      <= '0;
                    end else begin
                        high_cnt <= hc_final;
                        win_cnt  <= win_cnt + ONE;
                    end
                end
                default: state <= WAIT_EDGE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Drives a fan PWM generator model into pwm_duty_decoder and checks the
// published duty against the speed the generator was programmed with.
module tb_pwm_duty_decoder;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 2 ** WIDTH;

    logic             clk = 1'b0;
    logic             arst;
    logic             pwm_in;
    logic [WIDTH-1:0] duty;
    logic             duty_valid;
    logic             duty_changed;
    logic             signal_lost;
    logic             busy_sync;

    pwm_duty_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .arst         (arst),
        .pwm_in       (pwm_in),
        .duty         (duty),
        .duty_valid   (duty_valid),
        .duty_changed (duty_changed),
        .signal_lost  (signal_lost),
        .busy_sync    (busy_sync)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cycle = 0;

    // Generator model: high for (speed+1) of every 256 clocks.
    logic             gen_on = 1'b0;
    logic [WIDTH-1:0] gen_cnt = '0;
    logic [WIDTH-1:0] gen_speed = '0;

    logic             v_seen;
    logic [WIDTH-1:0] v_duty;
    logic             v_ch;
    logic             v_lost;
    logic             v_busy;
    logic             got;
    int               valid_cycle;
    int               prev_valid_cycle;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic check_range(input string tag, input int observed, input int lo, input int hi);
        total_cnt++;
        assert (observed >= lo && observed <= hi) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    endtask

    // Sample outputs on the falling edge, then drive the next generator sample.
    task automatic apply_stimulus();
        @(negedge clk);
        cycle++;
        v_seen = duty_valid;
        v_duty = duty;
        v_ch   = duty_changed;
        v_lost = signal_lost;
        v_busy = busy_sync;
        pwm_in = gen_on && (gen_cnt <= gen_speed);
        gen_cnt = gen_cnt + 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        got = 1'b0;
        for (int i = 0; i < 4 * PERIOD && !got; i++) begin
            apply_stimulus();
            if (v_seen) got = 1'b1;
        end
        check_output({tag, " arrives"}, {31'd0, got}, 32'd1);
        prev_valid_cycle = valid_cycle;
        valid_cycle = cycle;
    endtask

    task automatic do_reset();
        arst    = 1'b1;
        gen_on  = 1'b0;
        gen_cnt = '0;
        pwm_in  = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus();
        arst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " duty"}, {24'd0, duty}, 32'd0);
        check_output({tag, " valid"}, {31'd0, duty_valid}, 32'd0);
        check_output({tag, " changed"}, {31'd0, duty_changed}, 32'd0);
        check_output({tag, " lost"}, {31'd0, signal_lost}, 32'd0);
        check_output({tag, " busy"}, {31'd0, busy_sync}, 32'd1);
    endtask

    task automatic start_gen(input logic [WIDTH-1:0] speed, input logic [WIDTH-1:0] phase);
        gen_speed = speed;
        gen_cnt   = phase;
        gen_on    = 1'b1;
    endtask

    int busy_count;
    int busy_drop_cycle;
    int spd;

    initial begin
        arst   = 1'b1;
        pwm_in = 1'b0;
        #1;
        check_reset_values("reset");
        do_reset();

        // Speed 128, aligned from the first edge.
        start_gen(8'd128, 8'd0);
        wait_valid("s128 first");
        check_output("s128 first duty", {24'd0, v_duty}, 32'd128);
        check_output("s128 first changed", {31'd0, v_ch}, 32'd1);
        check_output("s128 first lost", {31'd0, v_lost}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_valid("s128 next");
            check_output("s128 duty", {24'd0, v_duty}, 32'd128);
            check_output("s128 changed", {31'd0, v_ch}, 32'd0);
            check_output("s128 spacing", valid_cycle - prev_valid_cycle, PERIOD);
        end

        // Speed switches 10 -> 200 in the middle of a generator period.
        do_reset();
        start_gen(8'd10, 8'd0);
        wait_valid("s10 a");
        check_output("s10 duty", {24'd0, v_duty}, 32'd10);
        wait_valid("s10 b");
        check_output("s10 duty", {24'd0, v_duty}, 32'd10);
        for (int i = 0; i < PERIOD + 8 && gen_cnt != 8'd128; i++) apply_stimulus();
        gen_speed = 8'd200;
        wait_valid("switch mid");
        check_output("switch mid changed", {31'd0, v_ch}, 32'd1);
        check_output("switch mid is intermediate",
                     {31'd0, (v_duty != 8'd10) && (v_duty != 8'd200)}, 32'd1);
        wait_valid("switch exact");
        check_output("switch exact duty", {24'd0, v_duty}, 32'd200);
        check_output("switch exact changed", {31'd0, v_ch}, 32'd1);
        wait_valid("switch steady");
        check_output("switch steady duty", {24'd0, v_duty}, 32'd200);
        check_output("switch steady changed", {31'd0, v_ch}, 32'd0);

        // Extremes: one high clock per period, and constant high.
        do_reset();
        start_gen(8'd0, 8'd0);
        for (int k = 0; k < 2; k++) begin
            wait_valid("s0");
            check_output("s0 duty", {24'd0, v_duty}, 32'd0);
            check_output("s0 lost", {31'd0, v_lost}, 32'd0);
        end
        do_reset();
        start_gen(8'd255, 8'd0);
        for (int k = 0; k < 2; k++) begin
            wait_valid("s255");
            check_output("s255 duty", {24'd0, v_duty}, 32'd255);
            check_output("s255 lost", {31'd0, v_lost}, 32'd0);
        end

        // Asynchronous reset at window sample ~100, then re-alignment.
        do_reset();
        start_gen(8'd50, 8'd0);
        wait_valid("s50");
        check_output("s50 duty", {24'd0, v_duty}, 32'd50);
        for (int i = 0; i < 100; i++) apply_stimulus();
        @(posedge clk);
        #3 arst = 1'b1;
        #1;
        check_reset_values("midreset");
        apply_stimulus();
        apply_stimulus();
        arst = 1'b0;
        wait_valid("after reset");
        check_output("after reset duty", {24'd0, v_duty}, 32'd50);
        check_output("after reset changed", {31'd0, v_ch}, 32'd1);
        check_output("after reset lost", {31'd0, v_lost}, 32'd0);

        // pwm_in held low: timeout into an unaligned window, loss of signal.
        do_reset();
        busy_count = 1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            apply_stimulus();
            if (!v_busy) break;
            busy_count++;
        end
        busy_drop_cycle = cycle;
        check_range("low busy length", busy_count, PERIOD - 1, PERIOD + 1);
        wait_valid("low");
        check_range("low first valid latency", valid_cycle - busy_drop_cycle, PERIOD - 2, PERIOD + 2);
        check_output("low duty", {24'd0, v_duty}, 32'd0);
        check_output("low lost", {31'd0, v_lost}, 32'd1);
        check_output("low changed", {31'd0, v_ch}, 32'd0);

        // Random speeds at random phases on the unaligned window grid.
        for (int seg = 0; seg < 4; seg++) begin
            spd = $urandom_range(0, 255);
            start_gen(WIDTH'(spd), WIDTH'($urandom_range(0, 255)));
            wait_valid("rand settle");
            wait_valid("rand settle");
            wait_valid("rand a");
            check_output("rand a duty", {24'd0, v_duty}, spd);
            check_output("rand a lost", {31'd0, v_lost}, 32'd0);
            wait_valid("rand b");
            check_output("rand b duty", {24'd0, v_duty}, spd);
            check_output("rand b changed", {31'd0, v_ch}, 32'd0);
        end

        // Toggling starts at a random phase straight out of reset.
        do_reset();
        start_gen(8'd77, WIDTH'($urandom_range(0, 255)));
        for (int k = 0; k < 3; k++) begin
            wait_valid("s77");
            check_output("s77 duty", {24'd0, v_duty}, 32'd77);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
